// File: rtl/conv2_mac_pair.sv
// conv2_mac_pair: dual-lane 5x5 multiply-accumulate for the conv2 layer.
// Both lanes share one activation stream. Each lane has its own weight
// stream and bias. Every TAPS accepted samples close one window. The window
// sum is then shifted, passed through ReLU, saturated to 8 bits and
// emitted as a pixel pair tagged with its window index.
module conv2_mac_pair #(
    parameter int DW          = 8,
    parameter int WW          = 8,
    parameter int BW          = 16,
    parameter int ACCW        = 24,
    parameter int TAPS        = 25,
    parameter int SHIFT       = 7,
    parameter int NUM_WINDOWS = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] act,
    input  logic [WW-1:0] w0,
    input  logic [WW-1:0] w1,
    input  logic [BW-1:0] bias0,
    input  logic [BW-1:0] bias1,
    output logic          out_valid,
    output logic [7:0]    out0,
    output logic [7:0]    out1,
    output logic [5:0]    out_idx,
    output logic          busy,
    output logic          done
);

    localparam int PW  = DW + WW + 1;
    localparam int TCW = $clog2(TAPS);
    localparam logic signed [ACCW-1:0] PIX_MAX = ACCW'(255);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    logic signed [ACCW-1:0] acc0, acc1;
    logic signed [ACCW-1:0] sum0, sum1;
    logic [TCW-1:0]         tap_cnt;
    logic [5:0]             win_cnt;
    logic                   pipe_valid;

    logic signed [PW-1:0]   prod0, prod1;
    logic signed [ACCW-1:0] prod0_ext, prod1_ext;
    logic signed [ACCW-1:0] bias0_ext, bias1_ext;
    logic signed [ACCW-1:0] r0, r1;
    logic                   last_tap;

    // The activation is unsigned, so a zero bit is prepended to make it a
    // non-negative signed operand. Products and biases are sign-extended to
    // the accumulator width.
    assign prod0     = $signed({1'b0, act}) * $signed(w0);
    assign prod1     = $signed({1'b0, act}) * $signed(w1);
    assign prod0_ext = {{(ACCW-PW){prod0[PW-1]}}, prod0};
    assign prod1_ext = {{(ACCW-PW){prod1[PW-1]}}, prod1};
    assign bias0_ext = {{(ACCW-BW){bias0[BW-1]}}, bias0};
    assign bias1_ext = {{(ACCW-BW){bias1[BW-1]}}, bias1};
    assign r0        = sum0 >>> SHIFT;
    assign r1        = sum1 >>> SHIFT;
    assign last_tap  = (state == RUN) && in_valid && (tap_cnt == TCW'(TAPS-1));

    // Apply ReLU to the shifted sum, then clip it to the 0..255 pixel range.
    function automatic logic [7:0] clamp_pixel(input logic signed [ACCW-1:0] r);
        logic [7:0] p;
        if (r[ACCW-1])
            p = 8'd0;
        else if (r > PIX_MAX)
            p = 8'hFF;
        else
            p = r[7:0];
        return p;
    endfunction

    // Run control, the accumulate stage and the registered output stage.
    // The output stage consumes a finished window sum one cycle after it is
    // captured. This frees the accumulators for the next window right away.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            acc0       <= '0;
            acc1       <= '0;
            sum0       <= '0;
            sum1       <= '0;
            tap_cnt    <= '0;
            win_cnt    <= '0;
            pipe_valid <= 1'b0;
            out_valid  <= 1'b0;
            out0       <= '0;
            out1       <= '0;
            out_idx    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            out_valid <= 1'b0;

            if (pipe_valid) begin
                pipe_valid <= 1'b0;
                out_valid  <= 1'b1;
                out0       <= clamp_pixel(r0);
                out1       <= clamp_pixel(r1);
                out_idx    <= win_cnt;
                win_cnt    <= win_cnt + 1'b1;
                if (win_cnt == 6'(NUM_WINDOWS-1)) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        acc0       <= '0;
                        acc1       <= '0;
                        tap_cnt    <= '0;
                        win_cnt    <= '0;
                        pipe_valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (last_tap) begin
                        sum0       <= acc0 + prod0_ext + bias0_ext;
                        sum1       <= acc1 + prod1_ext + bias1_ext;
                        acc0       <= '0;
                        acc1       <= '0;
                        tap_cnt    <= '0;
                        pipe_valid <= 1'b1;
                    end else if (in_valid) begin
                        acc0    <= acc0 + prod0_ext;
                        acc1    <= acc1 + prod1_ext;
                        tap_cnt <= tap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
